// File: rtl/qeciphy_rx_link_monitor.sv
// Receive link monitor: hunts, verifies and tracks the FAP word, forwards payload with FAPs stripped.
// Per-frame CRC-16 checking is built only when QECIPHY_RX_MON_CRC_EN is defined.
module qeciphy_rx_link_monitor #(
  parameter int unsigned FAP_PERIOD  = 64,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter logic [31:0] FAP_PATTERN = 32'hFAB0_5A0F
) (
  input  logic        axis_clk,
  input  logic        axis_rst_n,
  input  logic [63:0] i_rx_tdata,
  input  logic        i_rx_tvalid,
  output logic [63:0] o_tdata,
  output logic        o_tvalid,
  output logic        o_rx_rdy,
  output logic        o_remote_rx_rdy,
  output logic        o_fap_missing,
  output logic        o_crc_error
);

  localparam int unsigned POS_W = $clog2(FAP_PERIOD);
  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FAP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [POS_W-1:0] pos_r, pos_s;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_s;
  logic             match_s, at_fap_s;
  logic             fwd_s, remote_s, fap_missing_s, crc_error_s;

  assign match_s  = (i_rx_tdata[63:32] == FAP_PATTERN);
  assign at_fap_s = (pos_r == POS_LAST);

  // Next-state, position/lock counters and FAP-driven flags for each valid word
  always_comb begin
    state_s       = state_r;
    pos_s         = pos_r;
    lock_cnt_s    = lock_cnt_r;
    fwd_s         = 1'b0;
    remote_s      = o_remote_rx_rdy;
    fap_missing_s = o_fap_missing;
    if (i_rx_tvalid) begin
      case (state_r)
        HUNT: begin
          if (match_s) begin
            lock_cnt_s = CNT_W'(1);
            pos_s      = '0;
            state_s    = (LOCK_COUNT > 1) ? VERIFY : LOCKED;
          end else begin
            lock_cnt_s = '0;
            pos_s      = '0;
            state_s    = HUNT;
          end
        end
        VERIFY: begin
          if (!at_fap_s) begin
            pos_s = pos_r + 1'b1;
          end else if (match_s) begin
            pos_s      = '0;
            lock_cnt_s = lock_cnt_r + 1'b1;
            if (lock_cnt_s == CNT_FULL) begin
              state_s = LOCKED;
            end else begin
              state_s = VERIFY;
            end
          end else begin
            pos_s      = '0;
            lock_cnt_s = '0;
            state_s    = HUNT;
          end
        end
        LOCKED: begin
          if (!at_fap_s) begin
            pos_s = pos_r + 1'b1;
            fwd_s = 1'b1;
          end else if (match_s) begin
            pos_s    = '0;
            remote_s = i_rx_tdata[16];
          end else begin
            pos_s         = '0;
            lock_cnt_s    = '0;
            remote_s      = 1'b0;
            fap_missing_s = 1'b1;
            state_s       = HUNT;
          end
        end
        default: begin
          pos_s      = '0;
          lock_cnt_s = '0;
          state_s    = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

`ifdef QECIPHY_RX_MON_CRC_EN
  // CRC-16 (0x1021), 64 data bits folded MSB first in one step
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [63:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] crc_r, crc_s;
  logic        crc_restart_s, crc_fold_s, crc_check_s;

  // Restart on every accepted FAP; only LOCKED FAPs are actually compared
  assign crc_restart_s = i_rx_tvalid && match_s && ((state_r == HUNT) || at_fap_s);
  assign crc_fold_s    = i_rx_tvalid && (state_r != HUNT) && !at_fap_s;
  assign crc_check_s   = i_rx_tvalid && (state_r == LOCKED) && at_fap_s && match_s;

  // CRC accumulator next value and sticky error decision
  always_comb begin
    crc_s       = crc_r;
    crc_error_s = o_crc_error;
    if (crc_restart_s) begin
      crc_s = 16'hFFFF;
      if (crc_check_s && (crc_r != i_rx_tdata[15:0])) begin
        crc_error_s = 1'b1;
      end else begin
        crc_error_s = o_crc_error;
      end
    end else if (crc_fold_s) begin
      crc_s = crc16_step(crc_r, i_rx_tdata);
    end else begin
      crc_s = crc_r;
    end
  end

  // CRC accumulator register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      crc_r <= 16'hFFFF;
    end else begin
      crc_r <= crc_s;
    end
  end
`else
  assign crc_error_s = 1'b0;
`endif

  // State, counters and all registered outputs
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_r         <= HUNT;
      pos_r           <= '0;
      lock_cnt_r      <= '0;
      o_tdata         <= 64'd0;
      o_tvalid        <= 1'b0;
      o_rx_rdy        <= 1'b0;
      o_remote_rx_rdy <= 1'b0;
      o_fap_missing   <= 1'b0;
      o_crc_error     <= 1'b0;
    end else begin
      state_r         <= state_s;
      pos_r           <= pos_s;
      lock_cnt_r      <= lock_cnt_s;
      o_tvalid        <= fwd_s;
      o_tdata         <= fwd_s ? i_rx_tdata : o_tdata;
      o_rx_rdy        <= (state_s == LOCKED);
      o_remote_rx_rdy <= remote_s;
      o_fap_missing   <= fap_missing_s;
      o_crc_error     <= crc_error_s;
    end
  end

endmodule

// File: tb/tb_qeciphy_rx_link_monitor.sv
// Self-checking bench for qeciphy_rx_link_monitor: payload scoreboard plus status checks after each FAP.
// Expected CRC-error behaviour follows QECIPHY_RX_MON_CRC_EN as defined for the build.
module tb_qeciphy_rx_link_monitor;

  localparam int          FP  = 64;
  localparam int          LC  = 4;
  localparam logic [31:0] PAT = 32'hFAB0_5A0F;
`ifdef QECIPHY_RX_MON_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic [63:0] i_rx_tdata = 64'd0;
  logic        i_rx_tvalid = 1'b0;
  logic [63:0] o_tdata;
  logic        o_tvalid, o_rx_rdy, o_remote_rx_rdy, o_fap_missing, o_crc_error;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_cnt = 0;
  logic        gap_en = 1'b0;
  logic        tb_locked = 1'b0;
  logic [15:0] tb_crc = 16'hFFFF;
  logic        exp_rdy = 1'b0, exp_remote = 1'b0, exp_miss = 1'b0, exp_crc = 1'b0;
  logic [63:0] exp_q[$];

  qeciphy_rx_link_monitor #(
    .FAP_PERIOD (FP),
    .LOCK_COUNT (LC),
    .FAP_PATTERN(PAT)
  ) dut (
    .axis_clk       (axis_clk),
    .axis_rst_n     (axis_rst_n),
    .i_rx_tdata     (i_rx_tdata),
    .i_rx_tvalid    (i_rx_tvalid),
    .o_tdata        (o_tdata),
    .o_tvalid       (o_tvalid),
    .o_rx_rdy       (o_rx_rdy),
    .o_remote_rx_rdy(o_remote_rx_rdy),
    .o_fap_missing  (o_fap_missing),
    .o_crc_error    (o_crc_error)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Byte-at-a-time CCITT formulation of the frame CRC
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [63:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      r = r ^ {w[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w[63:32] == PAT) w[32] = ~w[32];
    return w;
  endfunction

  task automatic check_status();
    check("rx_rdy",        {63'd0, o_rx_rdy},        {63'd0, exp_rdy});
    check("remote_rx_rdy", {63'd0, o_remote_rx_rdy}, {63'd0, exp_remote});
    check("fap_missing",   {63'd0, o_fap_missing},   {63'd0, exp_miss});
    check("crc_error",     {63'd0, o_crc_error},     {63'd0, exp_crc});
  endtask

  task automatic check_all_zero();
    check("rst_tdata",  o_tdata, 64'd0);
    check("rst_tvalid", {63'd0, o_tvalid}, 64'd0);
    exp_rdy = 1'b0; exp_remote = 1'b0; exp_miss = 1'b0; exp_crc = 1'b0;
    check_status();
  endtask

  // One clock: drive on the falling edge, score any output just after the rising edge
  task automatic cycle(input logic v, input logic [63:0] d, input logic fwd);
    @(negedge axis_clk);
    i_rx_tvalid = v;
    i_rx_tdata  = d;
    if (v && fwd) exp_q.push_back(d);
    @(posedge axis_clk);
    #1;
    cyc_cnt++;
    if (o_tvalid) begin
      if (exp_q.size() == 0) check("unexpected_tvalid", {63'd0, o_tvalid}, 64'd0);
      else check("payload", o_tdata, exp_q.pop_front());
    end
  endtask

  task automatic send(input logic [63:0] d, input logic fwd);
    if (gap_en && (cyc_cnt % 3 == 2)) cycle(1'b0, {PAT, $urandom}, 1'b0);
    cycle(1'b1, d, fwd);
  endtask

  task automatic payload(input int n, input int flip_idx);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = rand_word();
      tb_crc = crc_fold(tb_crc, w);
      if (i == flip_idx) w[0] = ~w[0];
      send(w, tb_locked);
    end
  endtask

  task automatic fap(input logic ok, input logic remote);
    logic [31:0] top;
    top = ok ? PAT : (PAT ^ 32'h0000_0001);
    send({top, 15'd0, remote, tb_crc}, 1'b0);
    tb_crc = 16'hFFFF;
    check_status();
    tb_locked = exp_rdy;
  endtask

  // FAP-led frames numbered from the first FAP seen in HUNT
  task automatic run_frames(input int n, input logic remote, input int start);
    for (int f = start; f < start + n; f++) begin
      exp_rdy = (f >= LC);
      if (f >= LC + 1) exp_remote = remote;
      fap(1'b1, remote);
      payload(FP - 1, -1);
    end
  endtask

  task automatic drain_check();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge axis_clk);
    axis_rst_n  = 1'b0;
    i_rx_tvalid = 1'b0;
    repeat (2) @(negedge axis_clk);
    check_all_zero();
    axis_rst_n = 1'b1;
    tb_locked  = 1'b0;
    tb_crc     = 16'hFFFF;
    exp_q.delete();
  endtask

  initial begin
    // Clean lock
    do_reset();
    run_frames(6, 1'b1, 1);
    drain_check();

    // False start: look-alike in HUNT, true FAPs 17 words later
    do_reset();
    for (int i = 0; i < 40; i++) send(rand_word(), 1'b0);
    send({PAT, 15'd0, 1'b1, 16'h1234}, 1'b0);
    check_status();
    for (int i = 0; i < 16; i++) send(rand_word(), 1'b0);
    fap(1'b1, 1'b1);
    payload(FP - 1, -1);
    run_frames(5, 1'b1, 1);
    drain_check();

    // tvalid gaps on every third cycle
    do_reset();
    gap_en = 1'b1;
    run_frames(6, 1'b1, 1);
    gap_en = 1'b0;
    drain_check();

    // Missing FAP on frame 10, flag sticky through a relock
    do_reset();
    run_frames(9, 1'b1, 1);
    exp_rdy = 1'b0; exp_remote = 1'b0; exp_miss = 1'b1;
    fap(1'b0, 1'b1);
    payload(FP - 1, -1);
    run_frames(5, 1'b1, 1);
    drain_check();

    // CRC error from one flipped payload bit; remote flag follows each FAP
    do_reset();
    run_frames(5, 1'b1, 1);
    fap(1'b1, 1'b1);
    payload(FP - 1, 20);
    exp_remote = 1'b0; exp_crc = CRC_EN;
    fap(1'b1, 1'b0);
    payload(FP - 1, -1);
    exp_remote = 1'b1;
    fap(1'b1, 1'b1);
    payload(10, -1);
    drain_check();

    // Asynchronous reset at word 30 of a locked frame
    do_reset();
    run_frames(5, 1'b1, 1);
    fap(1'b1, 1'b1);
    payload(30, -1);
    drain_check();
    #2;
    axis_rst_n  = 1'b0;
    i_rx_tvalid = 1'b0;
    #1;
    check_all_zero();
    tb_locked = 1'b0;
    tb_crc    = 16'hFFFF;
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    payload(10, -1);
    run_frames(4, 1'b1, 1);
    drain_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
